// File: rtl/ccff_chain_programmer_if.sv
// Bundle of host, readback and chain-side signals for one configuration chain.
interface ccff_chain_programmer_if #(
  parameter int unsigned WORD_W = 8
);
  logic              start;
  logic              busy;
  logic              done;
  logic              din_valid;
  logic [WORD_W-1:0] din_data;
  logic              din_ready;
  logic              ccff_head;
  logic              shift_en;
  logic              ccff_tail;
  logic              rb_valid;
  logic [WORD_W-1:0] rb_data;

  // Host plus chain-model side.
  modport master (
    output start, din_valid, din_data, ccff_tail,
    input  busy, done, din_ready, ccff_head, shift_en, rb_valid, rb_data
  );

  // Programmer side.
  modport slave (
    input  start, din_valid, din_data, ccff_tail,
    output busy, done, din_ready, ccff_head, shift_en, rb_valid, rb_data
  );
endinterface

// File: rtl/ccff_chain_programmer.sv
// Serialises host bitstream words onto a configuration chain head and
// collects the previous chain contents from the tail into readback words.
module ccff_chain_programmer #(
  parameter int unsigned CHAIN_LEN = 28,
  parameter int unsigned WORD_W    = 8
) (
  input  logic                    prog_clk,
  input  logic                    pReset,
  ccff_chain_programmer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned RB_W  = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(WORD_W);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_nx;
  logic [RB_W-1:0]   word_bits;
  logic [RB_W-1:0]   word_bits_nx;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_cnt_nx;
  logic [CNT_W-1:0]  bits_rem;
  logic [RB_W-1:0]   rb_cnt;
  logic [RB_W-1:0]   rb_cnt_nx;
  logic [WORD_W-1:0] rb_shreg;
  logic [WORD_W-1:0] rb_shreg_nx;
  logic [WORD_W-1:0] rb_word;
  logic              rb_fire;

  logic              busy_q;
  logic              done_q;
  logic              din_ready_q;
  logic              shift_en_q;
  logic              ccff_head_q;
  logic              rb_valid_q;
  logic [WORD_W-1:0] rb_data_q;

  // State register.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, word loading, bit serialisation and readback assembly.
  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    word_bits_nx = word_bits;
    bit_cnt_nx   = bit_cnt;
    rb_cnt_nx    = rb_cnt;
    rb_shreg_nx  = rb_shreg;
    rb_fire      = 1'b0;
    bits_rem     = LAST_BIT - bit_cnt;
    rb_word      = rb_shreg | (WORD_W'(bus.ccff_tail) << rb_cnt);

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx    = LOAD;
          bit_cnt_nx  = '0;
          rb_cnt_nx   = '0;
          rb_shreg_nx = '0;
        end
      end

      LOAD: begin
        if (bus.din_valid) begin
          shreg_nx     = bus.din_data;
          // The final word may be only partly used; its upper bits are dropped.
          word_bits_nx = (bits_rem >= WORD_LEN) ? RB_W'(WORD_W) : RB_W'(bits_rem);
          state_nx     = SHIFT;
        end
      end

      SHIFT: begin
        shreg_nx     = shreg >> 1;
        bit_cnt_nx   = bit_cnt + CNT_W'(1);
        word_bits_nx = word_bits - RB_W'(1);
        // A full readback word, or the tail of the image, is flushed at this edge.
        if ((rb_cnt == RB_W'(WORD_W - 1)) || (bit_cnt_nx == LAST_BIT)) begin
          rb_fire     = 1'b1;
          rb_cnt_nx   = '0;
          rb_shreg_nx = '0;
        end else begin
          rb_cnt_nx   = rb_cnt + RB_W'(1);
          rb_shreg_nx = rb_word;
        end
        if (word_bits == RB_W'(1)) begin
          state_nx = (bit_cnt_nx == LAST_BIT) ? DONE : LOAD;
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath registers and registered outputs derived from the next state.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      shreg       <= '0;
      word_bits   <= '0;
      bit_cnt     <= '0;
      rb_cnt      <= '0;
      rb_shreg    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      din_ready_q <= 1'b0;
      shift_en_q  <= 1'b0;
      ccff_head_q <= 1'b0;
      rb_valid_q  <= 1'b0;
      rb_data_q   <= '0;
    end else begin
      shreg       <= shreg_nx;
      word_bits   <= word_bits_nx;
      bit_cnt     <= bit_cnt_nx;
      rb_cnt      <= rb_cnt_nx;
      rb_shreg    <= rb_shreg_nx;
      busy_q      <= (state_nx == LOAD) || (state_nx == SHIFT);
      done_q      <= (state_nx == DONE);
      din_ready_q <= (state_nx == LOAD);
      shift_en_q  <= (state_nx == SHIFT);
      ccff_head_q <= (state_nx == SHIFT) & shreg_nx[0];
      rb_valid_q  <= rb_fire;
      if (rb_fire) begin
        rb_data_q <= rb_word;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.din_ready = din_ready_q;
  assign bus.shift_en  = shift_en_q;
  assign bus.ccff_head = ccff_head_q;
  assign bus.rb_valid  = rb_valid_q;
  assign bus.rb_data   = rb_data_q;

endmodule
